// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver: state encoding,
// default word width and a counter-width helper.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam int DEFAULT_DATA_W = 8;

    // Bit-index width for a DATA_W-bit word; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional
// parity bit, stop bit. Results are registered and pulsed once per frame.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        good_cnt,
    output rx_state_e         state_dbg
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Input qualification: din is consumed only on a rising edge where
    // bit_en=1; on any other edge the FSM and datapath hold, and only the
    // one-cycle frame_done/data_valid pulses drop back to 0. No backpressure.

    rx_state_e         state, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  bit_cnt, cnt_next;
    logic              par_acc, par_next;
    logic              par_fail, par_fail_next;
    logic [DATA_W-1:0] data_next;
    logic              perr_next, ferr_next, done_next, valid_next;
    logic [7:0]        good_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            par_fail   <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            data_valid <= 1'b0;
            good_cnt   <= 8'd0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= cnt_next;
            par_acc    <= par_next;
            par_fail   <= par_fail_next;
            data_out   <= data_next;
            parity_err <= perr_next;
            frame_err  <= ferr_next;
            frame_done <= done_next;
            data_valid <= valid_next;
            good_cnt   <= good_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        cnt_next      = bit_cnt;
        par_next      = par_acc;
        par_fail_next = par_fail;
        data_next     = data_out;
        perr_next     = parity_err;
        ferr_next     = frame_err;
        done_next     = 1'b0;
        valid_next    = 1'b0;
        good_next     = good_cnt;

        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!din) begin
                        state_next    = DATA;
                        shift_next    = '0;
                        cnt_next      = '0;
                        par_next      = 1'b0;
                        par_fail_next = 1'b0;
                    end
                end
                DATA: begin
                    shift_next[bit_cnt] = din;
                    par_next            = par_acc ^ din;
                    cnt_next            = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_next = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_fail_next = ((par_acc ^ din) != PARITY_ODD);
                    state_next    = STOP;
                end
                STOP: begin
                    // Always return to IDLE here, even when din=0, so a bad
                    // stop bit is never mistaken for the next start bit.
                    state_next = IDLE;
                    data_next  = shift_reg;
                    perr_next  = par_fail;
                    ferr_next  = !din;
                    done_next  = 1'b1;
                    valid_next = !par_fail && din;
                    if (!par_fail && din) begin
                        good_next = good_cnt + 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized self-checking bench for serial_frame_rx against a frame-level
// reference model (popcount parity, queue of expected words).
module tb_serial_frame_rx;
    import serial_rx_pkg::*;

    localparam int DATA_W     = 8;
    localparam bit PARITY_EN  = 1'b1;
    localparam bit PARITY_ODD = 1'b0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bit_en = 1'b0;
    logic              din = 1'b1;
    logic [DATA_W-1:0] data_out;
    logic              frame_done, data_valid, parity_err, frame_err, busy;
    logic [7:0]        good_cnt;
    rx_state_e         state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_valid = 0;
    int mdl_good = 0;
    logic [DATA_W-1:0] exp_q[$];

    serial_frame_rx #(
        .DATA_W(DATA_W), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .din(din),
        .data_out(data_out), .frame_done(frame_done), .data_valid(data_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy),
        .good_cnt(good_cnt), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard: every frame_done must match the oldest expected word
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) check("sb_spurious_done", 32'd1, 32'd0);
            else check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
        if (data_valid === 1'b1) n_valid++;
    end

    // driver tasks
    task automatic drive(input logic en, input logic d);
        bit_en = en;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) drive(1'b0, 1'($urandom_range(0, 1)));
        drive(1'b1, b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0);
        rst = 1'b0;
        mdl_good = 0;
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input bit bad_par,
                              input logic stop, input int gap);
        int   good_pbit;
        logic pbit, exp_perr, exp_ferr, exp_valid;
        good_pbit = ($countones(data) + int'(PARITY_ODD)) % 2;
        pbit      = bad_par ? 1'(1 - good_pbit) : 1'(good_pbit);
        exp_perr  = PARITY_EN && bad_par;
        exp_ferr  = !stop;
        exp_valid = !exp_perr && !exp_ferr;
        if (exp_valid) mdl_good = (mdl_good + 1) % 256;
        exp_q.push_back(data);

        send_bit(1'b0, gap);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < DATA_W; i++) send_bit(data[i], gap);
        if (PARITY_EN) send_bit(pbit, gap);
        send_bit(stop, gap);

        check("data_out", 32'(data_out), 32'(data));
        check("frame_done", 32'(frame_done), 32'd1);
        check("data_valid", 32'(data_valid), 32'(exp_valid));
        check("parity_err", 32'(parity_err), 32'(exp_perr));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("good_cnt", 32'(good_cnt), 32'(mdl_good));
        check("busy_after_stop", 32'(busy), 32'd0);
        check("state_idle", 32'(state_dbg), 32'(IDLE));

        drive(1'b0, 1'b1);
        check("done_one_cycle", 32'(frame_done), 32'd0);
        check("valid_one_cycle", 32'(data_valid), 32'd0);
        check("data_held", 32'(data_out), 32'(data));
    endtask

    initial begin
        int snap_done, snap_valid;
        logic [DATA_W-1:0] rdata;

        do_reset();
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_flags", {28'd0, frame_done, data_valid, parity_err, frame_err}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_good_cnt", 32'(good_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        send_frame(8'hA5, 1'b0, 1'b1, 0);   // clean frame
        send_frame(8'h01, 1'b1, 1'b1, 0);   // bad parity
        send_frame(8'h3C, 1'b0, 1'b0, 0);   // bad stop
        send_frame(8'h5A, 1'b0, 1'b1, 2);   // bit_en every 3rd cycle

        // abort after 4 data bits; rst asserted with bit_en=1, din=0
        snap_done = n_done;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        do_reset();
        check("abort_data_out", 32'(data_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_good_cnt", 32'(good_cnt), 32'd0);
        repeat (3) drive(1'b1, 1'b1);
        check("abort_no_pulse", 32'(n_done), 32'(snap_done));
        send_frame(8'h0F, 1'b0, 1'b1, 0);
        check("after_abort_good", 32'(good_cnt), 32'd1);

        // randomized frames with occasional errors and gaps
        for (int f = 0; f < 40; f++) begin
            rdata = DATA_W'($urandom);
            send_frame(rdata, ($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 4) != 0), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) drive(1'b1, 1'b1);
        end

        // good_cnt wrap over 256 clean frames
        do_reset();
        snap_valid = n_valid;
        for (int f = 0; f < 256; f++) begin
            rdata = DATA_W'($urandom);
            send_frame(rdata, 1'b0, 1'b1, 0);
        end
        check("wrap_good_cnt", 32'(good_cnt), 32'd0);
        check("wrap_valid_pulses", 32'(n_valid - snap_valid), 32'd256);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
